// File: rtl/aes_key_sequencer_pkg.sv
// Shared AES definitions for the key sequencer and the encryption path.
//   - seq_state_e : sequencer FSM states
//   - ROUND_INIT / ROUND_10 : first and last round numbers for AES-128
//   - rcon_lookup : round constant indexed by target round 1..10
//   - gf_mul / sbox : GF(2^8) multiply and AES S-box byte lookup
package aes_key_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } seq_state_e;

    localparam logic [3:0] ROUND_INIT = 4'd0;
    localparam logic [3:0] ROUND_10   = 4'd10;

    function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the multiplicative inverse
    // (and maps 0 to 0). Built as x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_sequencer_expand.sv
// One AES-128 key-expansion step, purely combinational.
//   key_i  [127:0] current round key, key_i[127:96] is word w0
//   rcon_i [7:0]   round constant for the target round
//   key_o  [127:0] next round key
module aes_key_expand_step
    import aes_key_sequencer_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_w3[8*i +: 8] = sbox(rot_w3[8*i +: 8]);
    end

    assign t  = sub_w3 ^ {rcon_i, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sequencer.sv
// Round controller and on-the-fly key expander feeding the AES round engine.
//   clk_in, rst_n_in      clock, async active-low reset
//   start_in, data_in,    new block request with plaintext and cipher key,
//   key_in                accepted only while ready_out=1
//   next_round_in         engine level; each rising edge advances one round
//   valid_in              engine block done; honoured only in RUN at round 10
//   ready_out, init_out   idle indicator, one-cycle launch pulse
//   data_out, round_out,  latched plaintext, current round, its round key
//   key_out
//
// state  | meaning
// IDLE   | waiting for start_in, ready_out high
// LAUNCH | init_out high for one cycle
// RUN    | stepping rounds on next_round_in rises until valid_in at round 10
module aes_key_sequencer
    import aes_key_sequencer_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         start_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         next_round_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         init_out,
    output logic [127:0] data_out,
    output logic [3:0]   round_out,
    output logic [127:0] key_out
);

    seq_state_e   state_q, state_d;
    logic         nr_q;
    logic [3:0]   round_q, round_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_next;
    logic         advance;

    aes_key_expand_step u_expand (
        .key_i  (key_q),
        .rcon_i (rcon_lookup(round_q + 4'd1)),
        .key_o  (key_next)
    );

    // nr_q tracks the level in every state, so a level already high when
    // RUN is entered does not count as a rise.
    assign advance = next_round_in & ~nr_q;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    data_d  = data_in;
                    key_d   = key_in;
                    round_d = ROUND_INIT;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (valid_in && round_q == ROUND_10) begin
                    state_d = IDLE;
                end else if (advance && round_q != ROUND_10) begin
                    round_d = round_q + 4'd1;
                    key_d   = key_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            nr_q    <= 1'b0;
            round_q <= ROUND_INIT;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            nr_q    <= next_round_in;
            round_q <= round_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign init_out  = (state_q == LAUNCH);
    assign data_out  = data_q;
    assign round_out = round_q;
    assign key_out   = key_q;

endmodule
